// File: rtl/serial_adder_ctrl_if.sv
// Command/result bundle between a requester and serial_adder_ctrl.
// The optional subtract request line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one operand bit per clock through a full adder made of two
// half adders. Defining SERIAL_ADDER_SUB_EN adds a subtract mode (a - b via ~b and carry-in 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hs1, hc1, s_bit, hc2, co_bit;
  logic [WIDTH:0]   acc_ext;

  adder_half_dataflow u_ha1 (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .s_o (hs1),
    .c_o (hc1)
  );

  adder_half_dataflow u_ha2 (
    .a_i (hs1),
    .b_i (c_q),
    .s_o (s_bit),
    .c_o (hc2)
  );

  assign co_bit  = hc1 | hc2;
  // New sum bit enters at the MSB; slicing the extended vector also works for WIDTH=1.
  assign acc_ext = {s_bit, acc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          opb_d   = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
`else
          opb_d   = bus.b;
          c_d     = 1'b0;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_ext[WIDTH:1];
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        c_d   = co_bit;
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          sum_d   = acc_ext[WIDTH:1];
          cout_d  = co_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// One-bit half adder used twice to form the serial full-adder cell.
module adder_half_dataflow (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8: expected {cout,sum} queued on issue,
// popped and compared on each done pulse.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one command at the next edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input bit push);
    logic [W:0] full;
    exp_t       e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else     full = {1'b0, a} + {1'b0, b};
`else
    full = {1'b0, a} + {1'b0, b};
`endif
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_add_timing();
    int   cyc;
    bit   ok;
    exp_t e;
    int   bad;
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      if (i < 7) @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL run_window: got %0d bad cycles, want 0", bad);
    end
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 1) begin
      n_fail++;
      $display("FAIL done_latency: got ok=%0d cyc=%0d, want done at cycle after E8", ok, cyc);
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.sum !== e.sum || bus.cout !== e.cout || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ff_01: got sum=%h cout=%b busy=%b, want sum=%h cout=%b busy=1",
               bus.sum, bus.cout, bus.busy, e.sum, e.cout);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_end: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [4] = '{8'hA5, 8'h5A, 8'h80, 8'h80};
    int   cyc;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(ops[2*k], ops[2*k+1], 1'b0, 1'b1);
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || bus.sum !== e.sum || bus.cout !== e.cout) begin
        n_fail++;
        $display("FAIL b2b_%0d: got ok=%0d sum=%h cout=%b, want sum=%h cout=%b",
                 k, ok, bus.sum, bus.cout, e.sum, e.cout);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.sum !== e.sum || bus.cout !== e.cout) begin
        n_fail++;
        $display("FAIL hold_%0d: got sum=%h cout=%b, want sum=%h cout=%b",
                 k, bus.sum, bus.cout, e.sum, e.cout);
      end
    end
  endtask

  task automatic test_ignore_start();
    int   cyc;
    bit   ok;
    exp_t e;
    int   extra;
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h66;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || bus.sum !== e.sum || bus.cout !== e.cout) begin
      n_fail++;
      $display("FAIL ignore_start: got ok=%0d sum=%h cout=%b, want sum=%h cout=%b",
               ok, bus.sum, bus.cout, e.sum, e.cout);
    end
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL no_extra_cmd: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int   cyc;
    bit   ok;
    exp_t e;
    int   extra;
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               bus.busy, bus.done, bus.sum, bus.cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", extra);
    end
    issue(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done(cyc, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || bus.sum !== e.sum || bus.cout !== e.cout) begin
      n_fail++;
      $display("FAIL after_abort: got ok=%0d sum=%h cout=%b, want sum=%h cout=%b",
               ok, bus.sum, bus.cout, e.sum, e.cout);
    end
  endtask

  task automatic test_random();
    int   cyc;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'b1);
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || bus.sum !== e.sum || bus.cout !== e.cout) begin
        n_fail++;
        $display("FAIL random_%0d: got ok=%0d sum=%h cout=%b, want sum=%h cout=%b",
                 k, ok, bus.sum, bus.cout, e.sum, e.cout);
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] ops [4] = '{8'h07, 8'h05, 8'h05, 8'h07};
    int   cyc;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(ops[2*k], ops[2*k+1], 1'b1, 1'b1);
      wait_done(cyc, ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || bus.sum !== e.sum || bus.cout !== e.cout) begin
        n_fail++;
        $display("FAIL sub_%0d: got ok=%0d sum=%h cout=%b, want sum=%h cout=%b",
                 k, ok, bus.sum, bus.cout, e.sum, e.cout);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_timing();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
